// File: rtl/rom_pkg.sv
// Shared ROM geometry and requester-index helpers for the ROM port arbiter.
package rom_pkg;
  localparam int ROM_ADDR_W = 4;
  localparam int ROM_DATA_W = 8;
  localparam int MAX_REQ    = 8;
  localparam int IDX_W      = $clog2(MAX_REQ);

  typedef logic [IDX_W-1:0] req_idx_t;

  // Successor index modulo n (n <= MAX_REQ).
  function automatic req_idx_t next_idx(req_idx_t w, int n);
    if (int'(w) + 1 >= n) return '0;
    return w + req_idx_t'(1);
  endfunction
endpackage

// File: rtl/rr_select.sv
// Combinational round-robin priority encoder: first eligible bit at or above ptr, wrapping.
module rr_select
  import rom_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] elig,
  input  req_idx_t           ptr,
  output logic [NUM_REQ-1:0] onehot,
  output req_idx_t           idx,
  output logic               any
);

  always_comb begin
    int c;
    c      = 0;
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      c = int'(ptr) + k;
      if (c >= NUM_REQ) c = c - NUM_REQ;
      if (!any && elig[c]) begin
        any       = 1'b1;
        idx       = req_idx_t'(c);
        onehot[c] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rom_port_arbiter.sv
// Round-robin arbiter sharing one ROM read port among NUM_REQ requesters.
// Optional per-requester saturating grant counters under ROM_ACCESS_CNT_EN.
module rom_port_arbiter
  import rom_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = ROM_ADDR_W,
  parameter int DATA_W  = ROM_DATA_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]         rdata,
  output logic                      rom_en,
  output logic [ADDR_W-1:0]         rom_addr,
  input  logic [DATA_W-1:0]         rom_data
`ifdef ROM_ACCESS_CNT_EN
  ,
  output logic [NUM_REQ*8-1:0]      grant_cnt
`endif
);

  logic [NUM_REQ-1:0][ADDR_W-1:0] addr_arr;
  logic [NUM_REQ-1:0]             elig;
  logic [NUM_REQ-1:0]             win_oh;
  req_idx_t                       win_idx;
  logic                           win_any;
  req_idx_t                       ptr;
  logic [ADDR_W-1:0]              win_addr;

  assign addr_arr = req_addr;
  // A requester granted this cycle sits out one edge, so a lone source alternates.
  assign elig     = req & ~gnt;

  rr_select #(.NUM_REQ(NUM_REQ)) u_sel (
    .elig   (elig),
    .ptr    (ptr),
    .onehot (win_oh),
    .idx    (win_idx),
    .any    (win_any)
  );

  always_comb begin
    win_addr = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (win_oh[i]) win_addr = win_addr | addr_arr[i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt      <= '0;
      rom_en   <= 1'b0;
      rom_addr <= '0;
      ptr      <= '0;
    end else if (win_any) begin
      gnt      <= win_oh;
      rom_en   <= 1'b1;
      rom_addr <= win_addr;
      ptr      <= next_idx(win_idx, NUM_REQ);
    end else begin
      gnt      <= '0;
      rom_en   <= 1'b0;
    end
  end

  // Return path: rvalid trails gnt by one cycle; rdata captures only on a live read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid <= '0;
      rdata  <= '0;
    end else begin
      rvalid <= gnt;
      if (|gnt) rdata <= rom_data;
    end
  end

`ifdef ROM_ACCESS_CNT_EN
  logic [NUM_REQ-1:0][7:0] cnt;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_cnt
    always_ff @(posedge clk or posedge rst) begin
      if (rst)                          cnt[i] <= '0;
      else if (gnt[i] && cnt[i] != 8'hFF) cnt[i] <= cnt[i] + 8'd1;
    end
  end

  assign grant_cnt = cnt;
`endif

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Directed table-driven bench for rom_port_arbiter (4 requesters), plus reset and counter sequences.
module tb_rom_port_arbiter;
  localparam int N = 4;

  logic        clk, rst;
  logic [N-1:0] req, gnt, rvalid;
  logic [N*4-1:0] req_addr;
  logic [7:0]  rdata, rom_data;
  logic        rom_en;
  logic [3:0]  rom_addr;
`ifdef ROM_ACCESS_CNT_EN
  logic [N*8-1:0] grant_cnt;
`endif

  int n_chk = 0;
  int n_fail = 0;

  rom_port_arbiter #(.NUM_REQ(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_addr (req_addr),
    .gnt      (gnt),
    .rvalid   (rvalid),
    .rdata    (rdata),
    .rom_en   (rom_en),
    .rom_addr (rom_addr),
    .rom_data (rom_data)
`ifdef ROM_ACCESS_CNT_EN
    ,
    .grant_cnt(grant_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] rw(logic [3:0] a);
    return {~a, a};
  endfunction

  // ROM contents: word at address a is {~a, a}.
  assign rom_data = rw(rom_addr);

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [15:0] addr;
    logic [3:0]  gnt;
    logic        en;
    logic [3:0]  raddr;
    logic [3:0]  rvalid;
    logic [7:0]  rdata;
  } vec_t;

  vec_t tv[23];

  function automatic vec_t mk(logic r, logic [3:0] q, logic [15:0] a, logic [3:0] g,
                              logic e, logic [3:0] ra, logic [3:0] rv, logic [7:0] rd);
    vec_t v;
    v.rst = r; v.req = q; v.addr = a; v.gnt = g; v.en = e;
    v.raddr = ra; v.rvalid = rv; v.rdata = rd;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(string tag, logic [3:0] g, logic e, logic [3:0] ra,
                         logic [3:0] rv, logic [7:0] rd);
    chk({tag, " gnt"},      32'(gnt),      32'(g));
    chk({tag, " rom_en"},   32'(rom_en),   32'(e));
    chk({tag, " rom_addr"}, 32'(rom_addr), 32'(ra));
    chk({tag, " rvalid"},   32'(rvalid),   32'(rv));
    chk({tag, " rdata"},    32'(rdata),    32'(rd));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // single request, then reset, simultaneous pair, pointer continuation,
    // four continuous, lone continuous, address change while waiting
    tv[0]  = mk(0, 4'b0001, 16'h0005, 4'b0001, 1, 4'h5, 4'b0000, 8'h00);
    tv[1]  = mk(0, 4'b0000, 16'h0000, 4'b0000, 0, 4'h5, 4'b0001, rw(4'h5));
    tv[2]  = mk(0, 4'b0000, 16'h0000, 4'b0000, 0, 4'h5, 4'b0000, rw(4'h5));
    tv[3]  = mk(1, 4'b0000, 16'h0000, 4'b0000, 0, 4'h0, 4'b0000, 8'h00);
    tv[4]  = mk(0, 4'b0101, 16'h0903, 4'b0001, 1, 4'h3, 4'b0000, 8'h00);
    tv[5]  = mk(0, 4'b0101, 16'h0903, 4'b0100, 1, 4'h9, 4'b0001, rw(4'h3));
    tv[6]  = mk(0, 4'b1001, 16'hC003, 4'b1000, 1, 4'hC, 4'b0100, rw(4'h9));
    tv[7]  = mk(0, 4'b0000, 16'h0000, 4'b0000, 0, 4'hC, 4'b1000, rw(4'hC));
    tv[8]  = mk(0, 4'b1111, 16'hDCBA, 4'b0001, 1, 4'hA, 4'b0000, rw(4'hC));
    tv[9]  = mk(0, 4'b1111, 16'hDCBA, 4'b0010, 1, 4'hB, 4'b0001, rw(4'hA));
    tv[10] = mk(0, 4'b1111, 16'hDCBA, 4'b0100, 1, 4'hC, 4'b0010, rw(4'hB));
    tv[11] = mk(0, 4'b1111, 16'hDCBA, 4'b1000, 1, 4'hD, 4'b0100, rw(4'hC));
    tv[12] = mk(0, 4'b1111, 16'hDCBA, 4'b0001, 1, 4'hA, 4'b1000, rw(4'hD));
    tv[13] = mk(0, 4'b1111, 16'hDCBA, 4'b0010, 1, 4'hB, 4'b0001, rw(4'hA));
    tv[14] = mk(0, 4'b0000, 16'h0000, 4'b0000, 0, 4'hB, 4'b0010, rw(4'hB));
    tv[15] = mk(0, 4'b0100, 16'h0700, 4'b0100, 1, 4'h7, 4'b0000, rw(4'hB));
    tv[16] = mk(0, 4'b0100, 16'h0700, 4'b0000, 0, 4'h7, 4'b0100, rw(4'h7));
    tv[17] = mk(0, 4'b0100, 16'h0700, 4'b0100, 1, 4'h7, 4'b0000, rw(4'h7));
    tv[18] = mk(0, 4'b0100, 16'h0700, 4'b0000, 0, 4'h7, 4'b0100, rw(4'h7));
    tv[19] = mk(0, 4'b0000, 16'h0000, 4'b0000, 0, 4'h7, 4'b0000, rw(4'h7));
    tv[20] = mk(0, 4'b0011, 16'h0021, 4'b0001, 1, 4'h1, 4'b0000, rw(4'h7));
    tv[21] = mk(0, 4'b0011, 16'h0061, 4'b0010, 1, 4'h6, 4'b0001, rw(4'h1));
    tv[22] = mk(0, 4'b0000, 16'h0000, 4'b0000, 0, 4'h6, 4'b0010, rw(4'h6));

    rst = 1'b1; req = '0; req_addr = '0;
    @(posedge clk); @(posedge clk); #1;
    chk_all("reset", 4'b0000, 1'b0, 4'h0, 4'b0000, 8'h00);

    for (int i = 0; i < 23; i++) begin
      rst = tv[i].rst; req = tv[i].req; req_addr = tv[i].addr;
      @(posedge clk); #1;
      chk_all($sformatf("v%0d", i), tv[i].gnt, tv[i].en, tv[i].raddr, tv[i].rvalid, tv[i].rdata);
    end

    // Reset asserted mid-flight while gnt=0010: read dropped, pointer back to 0.
    req = 4'b0010; req_addr = 16'h00E0;
    @(posedge clk); #1;
    chk("mid gnt", 32'(gnt), 32'(4'b0010));
    chk("mid rom_addr", 32'(rom_addr), 32'h0000_000E);
    #2 rst = 1'b1;
    #1 chk_all("async_rst", 4'b0000, 1'b0, 4'h0, 4'b0000, 8'h00);
    @(posedge clk); #1;
    rst = 1'b0; req = 4'b1010; req_addr = 16'h3050;
    @(posedge clk); #1;
    chk("post_rst rvalid", 32'(rvalid), 32'(4'b0000));
    chk("post_rst gnt ptr0", 32'(gnt), 32'(4'b0010));
    chk("post_rst rom_addr", 32'(rom_addr), 32'h0000_0005);
    req = '0;
    @(posedge clk); #1;

`ifdef ROM_ACCESS_CNT_EN
    rst = 1'b1; #2;
    chk("cnt reset", 32'(grant_cnt), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; req = 4'b0010; req_addr = 16'h0090;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
    end
    chk("cnt slice1 after 10", 32'(grant_cnt[15:8]), 32'd10);
    for (int c = 20; c < 620; c++) begin
      @(posedge clk); #1;
    end
    chk("cnt slice1 sat", 32'(grant_cnt[15:8]), 32'hFF);
    chk("cnt slice0", 32'(grant_cnt[7:0]), 32'h0);
    chk("cnt slices2-3", 32'(grant_cnt[31:16]), 32'h0);
    req = '0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
